csa_final_adder: RTL and testbench



---
 rtl/csa_pkg.sv | 17 +
 rtl/csa_3to2_row.sv | 23 ++
 rtl/csa_final_adder.sv | 148 ++++++++++++++
 tb/tb_csa_final_adder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save final adder and future adder trees.
// Contents: result width helper, default carry-propagate split point,
// and the per-stage valid vector type.
package csa_pkg;

  // Default bit position where the carry-propagate add is split.
  localparam int unsigned SPLIT_DEFAULT = 24;

  // One valid flag per pipeline stage: [0]=S1, [1]=S2, [2]=S3 (output).
  typedef logic [2:0] stage_valid_t;

  // X + 2Y + 4Z peaks at 7*(2^width-1), which always fits width+3 bits.
  function automatic int unsigned sum_width(input int unsigned width);
    return width + 3;
  endfunction

endpackage

// File: rtl/csa_3to2_row.sv
// Combinational 3:2 carry-save compressor row.
// Ports:
//   a, b, c : W-bit addends
//   s       : bitwise sum  a ^ b ^ c
//   cy      : majority(a, b, c) shifted left by one, truncated to W bits
// a + b + c == s + cy whenever the true total fits in W bits.
module csa_3to2_row #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cy
);

  logic [W-1:0] maj;

  assign s   = a ^ b ^ c;
  assign maj = (a & b) | (a & c) | (b & c);
  assign cy  = W'({maj, 1'b0});

endmodule

// File: rtl/csa_final_adder.sv
// Final stage of the spatial-filter adder tree: resolves X + 2Y + 4Z.
// Three register stages: S1 = 3:2 carry-save row, S2 = lower-half
// carry-propagate add, S3 = upper-half add with the S2 carry (output).
// Valid/ready stream: the whole pipeline freezes while the output is
// presented but not accepted.
// Optional feature macro: CSA_FINAL_ROUND_EN -- when defined, the output is
// (sum + 2^(SHIFT-1)) >> SHIFT (round half up); otherwise SHIFT is ignored.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : input handshake (in_ready is combinational)
//   X, Y, Z              : WIDTH-bit operands of weight 1, 2, 4
//   sum_valid, sum_ready : output handshake
//   sum                  : WIDTH+3-bit unsigned result
module csa_final_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = 45,
  parameter int unsigned SPLIT = SPLIT_DEFAULT,
  parameter int unsigned SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            X,
  input  logic [WIDTH-1:0]            Y,
  input  logic [WIDTH-1:0]            Z,
  output logic                        sum_valid,
  input  logic                        sum_ready,
  output logic [sum_width(WIDTH)-1:0] sum
);

  localparam int unsigned SW = sum_width(WIDTH);
  localparam int unsigned HW = SW - SPLIT;
  localparam int unsigned LW = SPLIT + 1;

  // Elaboration-time parameter range checks.
  if (SPLIT == 0 || SPLIT >= SW) begin : g_split_range
    $error("csa_final_adder: SPLIT must be in 1..WIDTH+2");
  end
  if (SHIFT > WIDTH) begin : g_shift_range
    $error("csa_final_adder: SHIFT must be in 0..WIDTH");
  end

  stage_valid_t vld;
  logic         stall;

  logic [SW-1:0] op_a;
  logic [SW-1:0] op_b;
  logic [SW-1:0] op_c;
  logic [SW-1:0] row_s;
  logic [SW-1:0] row_cy;
  logic [SW-1:0] s1_d;
  logic [SW-1:0] cy1_d;

  logic [SW-1:0] s1_q;
  logic [SW-1:0] cy1_q;

  logic [LW-1:0] lo_c;
  logic [SPLIT-1:0] lo_q;
  logic          carry_q;
  logic [HW-1:0] s_hi_q;
  logic [HW-1:0] cy_hi_q;

  logic [HW-1:0] hi_c;
  logic [SW-1:0] full_c;
  logic [SW-1:0] sum_d;
  logic [SW-1:0] sum_q;

  // Output-driven stall freezes every stage, valid flags included.
  assign stall     = vld[2] && !sum_ready;
  assign in_ready  = !stall;
  assign sum_valid = vld[2];
  assign sum       = sum_q;

  // Weighted, zero-extended operands.
  assign op_a = SW'(X);
  assign op_b = SW'({Y, 1'b0});
  assign op_c = SW'({Z, 2'b00});

  csa_3to2_row #(.W(SW)) u_row (
    .a  (op_a),
    .b  (op_b),
    .c  (op_c),
    .s  (row_s),
    .cy (row_cy)
  );

`ifdef CSA_FINAL_ROUND_EN
  // Rounding constant folded in as a fourth operand by a second 3:2 row;
  // with a constant third input this row reduces to a handful of gates.
  localparam logic [SW-1:0] RND = (SHIFT > 0) ? (SW'(1) << (SHIFT - 1)) : '0;

  csa_3to2_row #(.W(SW)) u_row_rnd (
    .a  (row_s),
    .b  (row_cy),
    .c  (RND),
    .s  (s1_d),
    .cy (cy1_d)
  );
`else
  assign s1_d  = row_s;
  assign cy1_d = row_cy;
`endif

  // Lower-half carry-propagate add; bit SPLIT is the carry into the upper half.
  assign lo_c = LW'(s1_q[SPLIT-1:0]) + LW'(cy1_q[SPLIT-1:0]);

  // Upper-half add completes the result.
  assign hi_c   = s_hi_q + cy_hi_q + HW'(carry_q);
  assign full_c = {hi_c, lo_q};

`ifdef CSA_FINAL_ROUND_EN
  assign sum_d = full_c >> SHIFT;
`else
  assign sum_d = full_c;
`endif

  // Pipeline registers; data only loads behind a valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld     <= '0;
      s1_q    <= '0;
      cy1_q   <= '0;
      lo_q    <= '0;
      carry_q <= 1'b0;
      s_hi_q  <= '0;
      cy_hi_q <= '0;
      sum_q   <= '0;
    end else if (!stall) begin
      vld <= {vld[1], vld[0], in_valid};
      if (in_valid) begin
        s1_q  <= s1_d;
        cy1_q <= cy1_d;
      end
      if (vld[0]) begin
        lo_q    <= lo_c[SPLIT-1:0];
        carry_q <= lo_c[SPLIT];
        s_hi_q  <= s1_q[SW-1:SPLIT];
        cy_hi_q <= cy1_q[SW-1:SPLIT];
      end
      if (vld[1]) begin
        sum_q <= sum_d;
      end
    end
  end

endmodule

// File: tb/tb_csa_final_adder.sv
// Scoreboard bench for csa_final_adder: accepted beats push a reference
// result, a negedge monitor pops and compares each delivered sum.
module tb_csa_final_adder;

  localparam int unsigned W  = 45;
  localparam int unsigned SW = W + 3;
`ifdef CSA_FINAL_ROUND_EN
  localparam int unsigned SH = 4;
`else
  localparam int unsigned SH = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  X;
  logic [W-1:0]  Y;
  logic [W-1:0]  Z;
  logic          sum_valid;
  logic          sum_ready;
  logic [SW-1:0] sum;

  int checks   = 0;
  int failures = 0;

  logic [SW-1:0] sb[$];
  logic          stalled_prev = 1'b0;
  logic [SW-1:0] held = '0;
  logic          rand_done;

  csa_final_adder #(.WIDTH(W), .SPLIT(24), .SHIFT(SH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .Z         (Z),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum       (sum)
  );

  always #5 clk = ~clk;

  // Reference: plain weighted sum, then optional round-half-up shift.
  function automatic logic [SW-1:0] ref_sum(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic [W-1:0] z);
    longint unsigned t;
    t = longint'(x) + 2 * longint'(y) + 4 * longint'(z);
`ifdef CSA_FINAL_ROUND_EN
    if (SH > 0) t = (t + (64'd1 << (SH - 1))) >> SH;
`endif
    return SW'(t);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor/scoreboard; handshakes seen at negedge complete at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (stalled_prev) begin
        check("hold_valid", 64'(sum_valid), 64'd1);
        check("hold_sum", 64'(sum), 64'(held));
      end
      if (sum_valid && !sum_ready) begin
        check("stall_in_ready", 64'(in_ready), 64'd0);
        stalled_prev = 1'b1;
        held = sum;
      end else begin
        stalled_prev = 1'b0;
      end
      if (sum_valid && sum_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sum: got %h expected no output", sum);
        end else begin
          check("sum", 64'(sum), 64'(sb.pop_front()));
        end
      end
      if (in_valid && in_ready) sb.push_back(ref_sum(X, Y, Z));
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Present one beat (call just after a posedge) and hold it until accepted.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    int   n;
    logic acc;
    n = 0;
    X = x; Y = y; Z = z; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || sum_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    return W'({$urandom(), $urandom()});
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; sum_ready = 1'b1;
    X = '0; Y = '0; Z = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sum_valid", 64'(sum_valid), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Basic beat and exact latency.
    X = 1; Y = 1; Z = 1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_valid", 64'(sum_valid), 64'd0);
    @(negedge clk);
    check("lat_c2_valid", 64'(sum_valid), 64'd0);
    @(negedge clk);
    check("lat_c3_valid", 64'(sum_valid), 64'd1);
    check("lat_c3_sum", 64'(sum), 64'(ref_sum(1, 1, 1)));
    @(negedge clk);
    check("lat_c4_valid", 64'(sum_valid), 64'd0);
    @(posedge clk);
    #1;
    drain();

    // Max operands and carry across the split boundary, back to back.
    send('1, '1, '1);
    send(W'(24'hFFFFFF), '0, '0);
    send(W'(24'hFFFFFF), W'(1), '0);
    send(W'(45'h0_FFFF_FF00_0000), W'(45'h0_0000_0080_0000), W'(45'h0_0000_0040_0000));
`ifdef CSA_FINAL_ROUND_EN
    send(W'(8), '0, '0);
    send(W'(7), '0, '0);
    send(W'(24), '0, '0);
`endif
    drain();

    // Backpressure: 5 beats, sum_ready low for 4 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 5; i++) send(rnd_op(), rnd_op(), rnd_op());
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        sum_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        sum_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random gaps and random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(rnd_op(), rnd_op(), rnd_op());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          sum_ready = ($urandom_range(0, 3) != 0);
        end
        sum_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-flight.
    send(rnd_op(), rnd_op(), rnd_op());
    send(rnd_op(), rnd_op(), rnd_op());
    @(posedge clk);
    #1;
    check("pre_reset_valid", 64'(sum_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("reset_async_valid", 64'(sum_valid), 64'd0);
    check("reset_async_sum", 64'(sum), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post_reset_idle_valid", 64'(sum_valid), 64'd0);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
